// File: rtl/mdu_controller.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MDU_DIVZERO_FLAG_EN: div_zero output, HI/LO kept on /0.
module mdu_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_s, sub_s, sum;
  logic [2*WIDTH-1:0] prod;

  // Operand magnitudes and the per-iteration adder/subtractor
  always_comb begin
    sa    = ~md_op[0] & op_a[WIDTH-1];
    sb    = ~md_op[0] & op_b[WIDTH-1];
    a_mag = sa ? (~op_a + 1'b1) : op_a;
    b_mag = sb ? (~op_b + 1'b1) : op_b;
    add_s = {1'b0, acc_q} + {1'b0, m_q};
    sub_s = {acc_q, q_q[WIDTH-1]} - {1'b0, m_q};
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;
    sum       = '0;
    prod      = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        state_d = S_IDLE;
        if (start && !flush) begin
          div_d     = md_op[1];
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          m_d       = md_op[1] ? b_mag : a_mag;
          q_d       = md_op[1] ? a_mag : b_mag;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (div_q) begin
            if (!sub_s[WIDTH]) begin
              acc_d = sub_s[WIDTH-1:0];
              q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
              q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            sum = q_q[0] ? add_s : {1'b0, acc_q};
            {acc_d, q_d} = {sum, q_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (div_q) begin
`ifdef MDU_DIVZERO_FLAG_EN
            if (m_q == '0) begin
              dz_d = 1'b1;
            end else begin
              lo_d = neg_res_q ? (~q_q + 1'b1) : q_q;
              hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
            end
`else
            lo_d = neg_res_q ? (~q_q + 1'b1) : q_q;
            hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
`endif
          end else begin
            prod = {acc_q, q_q};
            if (neg_res_q) prod = ~prod + 1'b1;
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
  assign div_zero = dz_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_mdu_controller.sv
// Directed vector bench for mdu_controller.
// Table of operations plus flush/reset/write corner sequences.
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  always #5 clk = ~clk;

  mdu_controller dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .md_op(md_op),
    .op_a(op_a),
    .op_b(op_b),
    .flush(flush),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tv[12];
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi, m_lo, eh, el;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // start at E0, optional injection of MTLO + start while busy
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit inj);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (inj && n == 5) begin
        lo_we = 1'b1; wdata = 32'h1234;
        start = 1'b1; md_op = 2'b01;
        op_a = 32'd5; op_b = 32'd5;
      end else begin
        lo_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    lo_we = 1'b0; start = 1'b0;
    chk("busy_len", n, 33);
    chk("done_pulse", {31'b0, done}, 1);
  endtask

  initial begin
    tv[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001};
    tv[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007,
               32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3]  = '{2'b11, 32'd100, 32'd0,
               32'd100, 32'hFFFFFFFF};
    tv[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000};
    tv[5]  = '{2'b01, 32'd2, 32'd3,
               32'd0, 32'd6};
    tv[6]  = '{2'b10, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD};
    tv[7]  = '{2'b11, 32'hFFFFFFFF, 32'h10,
               32'hF, 32'h0FFFFFFF};
    tv[8]  = '{2'b00, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h0};
    tv[9]  = '{2'b10, 32'hFFFFFFF0, 32'd0,
               32'hFFFFFFF0, 32'h00000001};
    tv[10] = '{2'b01, 32'h12345678, 32'h10,
               32'h1, 32'h23456780};
    tv[11] = '{2'b10, 32'hFFFFFF9C, 32'd7,
               32'hFFFFFFFE, 32'hFFFFFFF2};

    reset_n = 1'b0; start = 1'b0; md_op = 2'b00;
    op_a = '0; op_b = '0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
`ifdef MDU_DIVZERO_FLAG_EN
    chk("rst_dz", {31'b0, div_zero}, 0);
`endif
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 12; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, 1'b0);
      eh = tv[i].ehi;
      el = tv[i].elo;
`ifdef MDU_DIVZERO_FLAG_EN
      if (tv[i].op[1] && tv[i].b == 0) begin
        eh = m_hi; el = m_lo;
        chk("dz_flag", {31'b0, div_zero}, 1);
      end else begin
        chk("dz_flag", {31'b0, div_zero}, 0);
      end
`endif
      chk($sformatf("v%0d_hi", i), hi, eh);
      chk($sformatf("v%0d_lo", i), lo, el);
      m_hi = eh; m_lo = el;
      @(negedge clk);
      chk("done_once", {31'b0, done}, 0);
    end

    // MTLO and start while busy are dropped
    run_op(2'b11, 32'd1000, 32'd7, 1'b1);
    chk("inj_hi", hi, 32'd6);
    chk("inj_lo", lo, 32'd142);

    // MTLO in idle
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi", hi, 32'd6);

    // MTHI on the same edge as an accepted start
    begin
      int n;
      hi_we = 1'b1; wdata = 32'hABCD;
      start = 1'b1; md_op = 2'b01; op_a = 32'd2; op_b = 32'd3;
      @(negedge clk);
      hi_we = 1'b0; start = 1'b0;
      chk("mthi_early", hi, 32'hABCD);
      chk("mthi_busy", {31'b0, busy}, 1);
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("mthi_len", n, 33);
      chk("mthi_done", {31'b0, done}, 1);
      chk("mthi_res_hi", hi, 32'd0);
      chk("mthi_res_lo", lo, 32'd6);
    end

    // flush in idle blocks start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = 2'b01;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_idle", {31'b0, busy}, 0);

    // flush at E10 mid-operation
    begin
      int dn;
      @(negedge clk);
      start = 1'b1; md_op = 2'b01;
      op_a = 32'h100; op_b = 32'h100;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 0);
      dn = 0;
      repeat (3) begin
        if (done) dn++;
        @(negedge clk);
      end
      chk("flush_nodone", dn, 0);
      chk("flush_hi", hi, 32'd0);
      chk("flush_lo", lo, 32'd6);
    end
    run_op(2'b01, 32'd9, 32'd9, 1'b0);
    chk("after_flush_hi", hi, 32'd0);
    chk("after_flush_lo", lo, 32'd81);

    // reset at E20 during a divide
    @(negedge clk);
    start = 1'b1; md_op = 2'b10;
    op_a = 32'd50; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_done", {31'b0, done}, 0);
    chk("mrst_hi", hi, 0);
    chk("mrst_lo", lo, 0);
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("mrst_idle", {31'b0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Iterative multiply/divide sequencer beside the main ALU in the EX stage of the pipeline CPU.
- Accepts MULT/MULTU/DIV/DIVU from the decoder and runs a 32-iteration shift-add or restoring-divide loop.
- Owns the HI/LO architectural registers and provides MTHI/MTLO writes and MFHI/MFLO reads.
- Drives busy so the hazard unit can stall the pipeline.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.
- CNT_W, 5, iteration counter width. It must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request to begin an operation
- md_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a  input  WIDTH  multiplicand or dividend
- op_b  input  WIDTH  multiplier or divisor
- flush  input  1  abort the in-flight operation (branch or exception squash)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; the pipeline must stall MDU-dependent instructions
- done  output  1  one-cycle pulse: HI/LO updated by the completed operation
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE, counter 0, busy=0, done=0, hi=0, lo=0. Reset overrides start, flush and the write enables. Reset during CALC or FIX discards the operation.
- States:
  - IDLE: start=1 and flush=0 latch operand magnitudes, the result-sign flags and md_op, clear the accumulator and counter, and go to CALC.
  - CALC: one iteration per edge, counter incremented. The edge where counter==WIDTH-1 goes to FIX.
  - FIX: applies sign correction, writes hi/lo, and goes to DONE.
  - DONE: done=1. It behaves as IDLE for start, write and flush, then returns to IDLE, or to CALC if start is accepted.
- Outputs: busy=1 exactly in CALC and FIX; done=1 exactly in DONE. Both are registered state decodes.
- Latency: start sampled at edge E0. Iterations run at E1..E32, hi/lo are written at E33, and done is high in the cycle after E33. busy is high for 33 cycles.
- Multiply:
  - Unsigned 32x32 magnitude product, 64 bits. {hi,lo} is the product.
  - MULT negates the 64-bit product when the operand signs differ.
- Divide:
  - Restoring division on magnitudes.
  - DIV negates the quotient when the signs differ. The remainder takes the sign of op_a.
  - DIVU uses no sign handling.
  - lo = quotient, hi = remainder.
- Divide by zero (macro absent): magnitude quotient 0xFFFFFFFF, remainder |op_a|, then normal sign fix.
  - DIVU a/0: lo=0xFFFFFFFF, hi=a.
  - DIV with a<0: lo=0x00000001, hi=a.
- 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. No trap.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - Take effect only when busy=0 and the state is not FIX; they are dropped while busy.
  - A write in the same cycle as an accepted start is performed. The later FIX result overwrites it.
- flush:
  - In CALC or FIX: go to IDLE next edge, hi/lo unchanged, no done.
  - In IDLE or DONE: suppresses start acceptance. Writes still occur.
- hi and lo are the register outputs directly, with no forwarding of the in-flight result.

Optional Feature:
MDU_DIVZERO_FLAG_EN
- Defined:
  - Adds output div_zero (1 bit, reset 0).
  - A DIV or DIVU whose latched op_b==0 still takes full latency, but FIX leaves hi/lo unchanged.
  - div_zero=1 together with done, for exactly that one cycle.
- Undefined: the port is absent and divide-by-zero results follow the rule above.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> busy 33 cycles; at E33 hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- MULT 0xFFFFFFFD*0x00000007 (-3*7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. With MDU_DIVZERO_FLAG_EN: hi/lo keep prior values, div_zero=1 with done.
- Start at E0, flush at E10 -> IDLE at E11; hi/lo keep prior values; no done; a new start at E12 is accepted.
- MTLO 0x1234 while busy -> ignored. MTHI 0xABCD in IDLE with start of MULTU 2*3 at the same edge -> hi=0xABCD after that edge; hi=0, lo=6 at E33.
- reset_n=0 at E20 mid-DIV -> next cycle busy=0, done=0, hi=lo=0; start ignored on the reset edge.
